// File: rtl/decoder_10b8b.sv
// Receive-side 10b/8b decoder: one code group per ena strobe, with running-disparity
// tracking, code/disparity violation flags, comma detect and a saturating error counter.
module decoder_10b8b #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ena,
  input  logic [9:0]           datain,
  output logic [7:0]           dataout,
  output logic                 ko,
  output logic                 valid,
  output logic                 code_err,
  output logic                 disp_err,
  output logic                 comma,
  output logic                 rd,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count
);

  // abcdei -> {legal, EDCBA}; both RD polarities map to the same value
  function automatic logic [5:0] dec6(input logic [5:0] v);
    case (v)
      6'b100111, 6'b011000: dec6 = {1'b1, 5'd0};
      6'b011101, 6'b100010: dec6 = {1'b1, 5'd1};
      6'b101101, 6'b010010: dec6 = {1'b1, 5'd2};
      6'b110001:            dec6 = {1'b1, 5'd3};
      6'b110101, 6'b001010: dec6 = {1'b1, 5'd4};
      6'b101001:            dec6 = {1'b1, 5'd5};
      6'b011001:            dec6 = {1'b1, 5'd6};
      6'b111000, 6'b000111: dec6 = {1'b1, 5'd7};
      6'b111001, 6'b000110: dec6 = {1'b1, 5'd8};
      6'b100101:            dec6 = {1'b1, 5'd9};
      6'b010101:            dec6 = {1'b1, 5'd10};
      6'b110100:            dec6 = {1'b1, 5'd11};
      6'b001101:            dec6 = {1'b1, 5'd12};
      6'b101100:            dec6 = {1'b1, 5'd13};
      6'b011100:            dec6 = {1'b1, 5'd14};
      6'b010111, 6'b101000: dec6 = {1'b1, 5'd15};
      6'b011011, 6'b100100: dec6 = {1'b1, 5'd16};
      6'b100011:            dec6 = {1'b1, 5'd17};
      6'b010011:            dec6 = {1'b1, 5'd18};
      6'b110010:            dec6 = {1'b1, 5'd19};
      6'b001011:            dec6 = {1'b1, 5'd20};
      6'b101010:            dec6 = {1'b1, 5'd21};
      6'b011010:            dec6 = {1'b1, 5'd22};
      6'b111010, 6'b000101: dec6 = {1'b1, 5'd23};
      6'b110011, 6'b001100: dec6 = {1'b1, 5'd24};
      6'b100110:            dec6 = {1'b1, 5'd25};
      6'b010110:            dec6 = {1'b1, 5'd26};
      6'b110110, 6'b001001: dec6 = {1'b1, 5'd27};
      6'b001110:            dec6 = {1'b1, 5'd28};
      6'b101110, 6'b010001: dec6 = {1'b1, 5'd29};
      6'b011110, 6'b100001: dec6 = {1'b1, 5'd30};
      6'b101011, 6'b010100: dec6 = {1'b1, 5'd31};
      6'b001111, 6'b110000: dec6 = {1'b1, 5'd28};
      default:              dec6 = {1'b0, 5'd0};
    endcase
  endfunction

  function automatic logic [2:0] dec4(input logic [3:0] v);
    case (v)
      4'b1011, 4'b0100:                   dec4 = 3'd0;
      4'b1001:                            dec4 = 3'd1;
      4'b0101:                            dec4 = 3'd2;
      4'b1100, 4'b0011:                   dec4 = 3'd3;
      4'b1101, 4'b0010:                   dec4 = 3'd4;
      4'b1010:                            dec4 = 3'd5;
      4'b0110:                            dec4 = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: dec4 = 3'd7;
      default:                            dec4 = 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] pop6(input logic [5:0] v);
    pop6 = '0;
    for (int i = 0; i < 6; i++) pop6 = pop6 + {2'b00, v[i]};
  endfunction

  function automatic logic [2:0] pop4(input logic [3:0] v);
    pop4 = '0;
    for (int i = 0; i < 4; i++) pop4 = pop4 + {2'b00, v[i]};
  endfunction

  logic [5:0] six;
  logic [3:0] four;
  logic [5:0] d6;
  logic [4:0] x5;
  logic [2:0] hgf, ones6, ones4;
  logic       k28, rd6, a7, set_neg, set_pos, set_k7;
  logic       a7_bad, p7_bad;
  logic       ce_nxt, de_nxt, rd_nxt, ko_nxt, comma_nxt;

  assign six  = datain[9:4];
  assign four = datain[3:0];

  always_comb begin
    d6      = dec6(six);
    x5      = d6[4:0];
    ones6   = pop6(six);
    ones4   = pop4(four);
    k28     = (six == 6'b001111) || (six == 6'b110000);
    // K28 at RD+ carries a complemented 4b sub-block
    hgf     = dec4((six == 6'b110000) ? ~four : four);
    set_neg = (x5 == 5'd17) || (x5 == 5'd18) || (x5 == 5'd20);
    set_pos = (x5 == 5'd11) || (x5 == 5'd13) || (x5 == 5'd14);
    set_k7  = k28 || (x5 == 5'd23) || (x5 == 5'd27) || (x5 == 5'd29) || (x5 == 5'd30);
    a7      = (four == 4'b0111) || (four == 4'b1000);

    // Out-of-range weights still steer rd toward the dominant symbol value
    if (ones6 > 3'd3)      rd6 = 1'b1;
    else if (ones6 < 3'd3) rd6 = 1'b0;
    else                   rd6 = rd;

    if (ones4 > 3'd2)      rd_nxt = 1'b1;
    else if (ones4 < 3'd2) rd_nxt = 1'b0;
    else                   rd_nxt = rd6;

    de_nxt = ((ones6 == 3'd4) && rd) || ((ones6 == 3'd2) && !rd) ||
             ((six == 6'b111000) && rd) || ((six == 6'b000111) && !rd) ||
             ((ones4 == 3'd3) && rd6) || ((ones4 == 3'd1) && !rd6) ||
             ((four == 4'b1100) && rd6) || ((four == 4'b0011) && !rd6);

    a7_bad = ((four == 4'b0111) && !(set_neg || set_k7)) ||
             ((four == 4'b1000) && !(set_pos || set_k7));
    p7_bad = ((four == 4'b1110) && !rd6 && set_neg) ||
             ((four == 4'b0001) && rd6 && set_pos) ||
             (k28 && ((four == 4'b1110) || (four == 4'b0001)));

    ce_nxt    = !d6[5] || (ones4 == 3'd0) || (ones4 == 3'd4) || a7_bad || p7_bad;
    ko_nxt    = !ce_nxt && (k28 || (a7 && set_k7));
    comma_nxt = (datain[9:3] == 7'b0011111) || (datain[9:3] == 7'b1100000);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataout  <= '0;
      ko       <= 1'b0;
      valid    <= 1'b0;
      code_err <= 1'b0;
      disp_err <= 1'b0;
      comma    <= 1'b0;
      rd       <= 1'b0;
    end else begin
      valid <= ena;
      if (ena) begin
        dataout  <= {hgf, x5};
        ko       <= ko_nxt;
        code_err <= ce_nxt;
        disp_err <= de_nxt;
        comma    <= comma_nxt;
        rd       <= rd_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (ena && (ce_nxt || de_nxt) && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_decoder_10b8b.sv
// Bench for decoder_10b8b: table of code groups with constant expectations fed through a
// scoreboard queue, plus hand sequences for hold, counter saturation/clear and mid-stream reset.
module tb_decoder_10b8b;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ena = 1'b0;
  logic [9:0] datain = '0;
  logic       err_clr = 1'b0;
  logic [7:0] dataout;
  logic       ko, valid, code_err, disp_err, comma, rd;
  logic [1:0] err_count;

  decoder_10b8b #(.ERR_CNT_W(2)) dut (
    .clk(clk), .reset(reset), .ena(ena), .datain(datain),
    .dataout(dataout), .ko(ko), .valid(valid), .code_err(code_err),
    .disp_err(disp_err), .comma(comma), .rd(rd),
    .err_clr(err_clr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] din;
    logic [7:0] dout;
    logic       ko, ce, de, comma, rd;
    logic       chk_dout, chk_de;
  } vec_t;

  typedef struct {
    vec_t       v;
    logic [1:0] cnt;
  } exp_t;

  vec_t tbl[15];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [1:0] err_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [9:0] din, input logic [7:0] dout, input logic k,
                              input logic ce, input logic de, input logic cm, input logic r);
    vec_t t;
    t.din = din; t.dout = dout; t.ko = k; t.ce = ce; t.de = de; t.comma = cm; t.rd = r;
    t.chk_dout = 1'b1; t.chk_de = 1'b1;
    return t;
  endfunction

  task automatic send(input vec_t v, input logic clr);
    exp_t e;
    @(negedge clk);
    datain = v.din; ena = 1'b1; err_clr = clr;
    if (clr) err_m = '0;
    else if ((v.ce || v.de) && err_m != 2'd3) err_m = err_m + 2'd1;
    e.v = v; e.cnt = err_m;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(valid), 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.v.chk_dout) chk($sformatf("dataout[%h]", e.v.din), 32'(dataout), 32'(e.v.dout));
        chk($sformatf("ko[%h]", e.v.din), 32'(ko), 32'(e.v.ko));
        chk($sformatf("code_err[%h]", e.v.din), 32'(code_err), 32'(e.v.ce));
        if (e.v.chk_de) chk($sformatf("disp_err[%h]", e.v.din), 32'(disp_err), 32'(e.v.de));
        chk($sformatf("comma[%h]", e.v.din), 32'(comma), 32'(e.v.comma));
        chk($sformatf("rd[%h]", e.v.din), 32'(rd), 32'(e.v.rd));
        chk($sformatf("err_count[%h]", e.v.din), 32'(err_count), 32'(e.cnt));
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_dataout"}, 32'(dataout), 32'd0);
    chk({tag, "_ko"}, 32'(ko), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_code_err"}, 32'(code_err), 32'd0);
    chk({tag, "_disp_err"}, 32'(disp_err), 32'd0);
    chk({tag, "_comma"}, 32'(comma), 32'd0);
    chk({tag, "_rd"}, 32'(rd), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    tbl[0]  = mk(10'h0FA, 8'hBC, 1, 0, 0, 1, 1); // K28.5 RD-
    tbl[1]  = mk(10'h305, 8'hBC, 1, 0, 0, 1, 0); // K28.5 RD+
    tbl[2]  = mk(10'h274, 8'h00, 0, 0, 0, 0, 0); // D0.0 RD-
    tbl[3]  = mk(10'h2AA, 8'hB5, 0, 0, 0, 0, 0); // D21.5
    tbl[4]  = mk(10'h237, 8'hF1, 0, 0, 0, 0, 1); // D17.7 A7 at RD-
    tbl[5]  = mk(10'h305, 8'hBC, 1, 0, 0, 1, 0); // back to RD-
    tbl[6]  = mk(10'h23E, 8'hF1, 0, 1, 0, 0, 1); // D17 with P7 where A7 needed
    tbl[7]  = mk(10'h348, 8'hEB, 0, 0, 0, 0, 0); // D11.7 A7 at RD+
    tbl[8]  = mk(10'h0F8, 8'hFC, 1, 0, 0, 1, 0); // K28.7 RD-
    tbl[9]  = mk(10'h3A8, 8'hF7, 1, 0, 0, 0, 0); // K23.7 RD-
    tbl[10] = mk(10'h31C, 8'h63, 0, 0, 0, 0, 0); // D3.3 RD-
    tbl[11] = mk(10'h313, 8'h63, 0, 0, 1, 0, 0); // 0011 at rd6=0
    tbl[12] = mk(10'h000, 8'h00, 0, 1, 0, 0, 0); // illegal all-zero
    tbl[12].chk_dout = 1'b0; tbl[12].chk_de = 1'b0;
    tbl[13] = mk(10'h0FA, 8'hBC, 1, 0, 0, 1, 1);
    tbl[14] = mk(10'h38B, 8'h07, 0, 0, 1, 0, 1); // 111000 and 1011 both at RD+

    #12;
    chk_zero("reset");
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < 15; i++) send(tbl[i], 1'b0);

    @(negedge clk); ena = 1'b0; datain = 10'h000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("hold_valid", 32'(valid), 32'd0);
      chk("hold_dataout", 32'(dataout), 32'h07);
      chk("hold_rd", 32'(rd), 32'd1);
      chk("hold_disp_err", 32'(disp_err), 32'd1);
      chk("hold_code_err", 32'(code_err), 32'd0);
      chk("hold_err_count", 32'(err_count), 32'd3);
    end

    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0; err_m = '0;
    #1 chk("clr_idle", 32'(err_count), 32'd0);

    for (int i = 0; i < 5; i++) send(tbl[12], 1'b0);
    send(tbl[12], 1'b1);

    @(negedge clk); err_clr = 1'b0; datain = 10'h0FA; ena = 1'b1;
    #2 reset = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk); ena = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("post_rst_valid", 32'(valid), 32'd0);
    chk("post_rst_rd", 32'(rd), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_10b8b.md
Name: decoder_10b8b

Overview:
- Receive-side 10b/8b decoder, the counterpart of the team's 8b/10b encoder.
- Takes one 10-bit code group per enabled clock and produces the 8-bit byte and the K flag.
- Tracks running disparity (RD) and flags code violations and disparity violations.
- Provides a comma indication for upstream word-alignment logic and a saturating error counter for link-quality monitoring.

Parameters:
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- ena  input  1  code-group strobe; datain is sampled only when high
- datain  input  10  code group; bit 9 = a (first transmitted) ... bit 0 = j; order is a,b,c,d,e,i,f,g,h,j
- dataout  output  8  decoded byte; bit 7 = H ... bit 0 = A
- ko  output  1  decoded group is a control (K) character
- valid  output  1  one-cycle pulse: dataout/flags were updated this cycle
- code_err  output  1  invalid code group
- disp_err  output  1  running-disparity violation
- comma  output  1  group contains 0011111 or 1100000 in bits a..g
- rd  output  1  current running disparity; 0 = negative, 1 = positive
- err_clr  input  1  synchronous clear of err_count
- err_count  output  ERR_CNT_W  saturating count of groups with code_err or disp_err

Behaviour:
- Reset (reset low, asynchronous): dataout=0, ko=0, valid=0, code_err=0, disp_err=0, comma=0, rd=0 (negative, matching encoder reset), err_count=0.
- Reset asserted mid-stream discards the in-flight group.
- Latency: the group sampled at edge N (ena=1) appears on the outputs after edge N, with valid=1 for that single cycle.
- With ena=0: outputs hold their values, valid=0, and rd is unchanged.
- 6b sub-block abcdei:
  - Decode to EDCBA per the standard 5b/6b table, accepting both RD polarities.
  - Ones count 4 = +2, 2 = -2, 3 = neutral; any other count is a code error.
  - 111000 is valid only at RD-, and 000111 only at RD+; otherwise raise disp_err.
- RD after 6b (rd6):
  - +2 sets rd6=1; -2 sets rd6=0; neutral leaves rd unchanged.
  - A +2 sub-block received at rd=1, or a -2 at rd=0, raises disp_err.
- 4b sub-block fghj, evaluated against rd6 (same rules as the 6b sub-block):
  - Ones count 3 = +2, 1 = -2, 2 = neutral; counts 0 or 4 are a code error.
  - 1100 is valid only at rd6=0, and 0011 only at rd6=1.
  - The new rd is set by fghj disparity; a neutral fghj leaves it at rd6.
- RD resynchronises to the received group even when disp_err is raised.
- Alternate x.A7 encoding:
  - fghj=0111 is legal only at rd6=0 with x ∈ {17,18,20} or Kx.7.
  - fghj=1000 is legal only at rd6=1 with x ∈ {11,13,14} or Kx.7.
  - Primary x.P7 (1110/0001) used where A7 is required is a code error.
- K characters: ko=1 for K28.0–K28.7 (abcdei 001111/110000) and for K23/27/29/30.7 (A7 form fghj). Any other K-like pattern is a code_err.
- On code_err: dataout is the best-effort table decode, ko=0, and rd is still updated per received disparity.
- comma is combinational on the sampled group, registered with the other outputs.
- err_count:
  - Increments by 1 on each valid group with code_err|disp_err.
  - Saturates at all-ones.
  - err_clr has priority over an increment in the same cycle; the counter reads 0 the next cycle.

Test Plan:
- Reset, then ena=1 with 0x0FA (K28.5 RD-) -> dataout=0xBC, ko=1, comma=1, rd=1, no errors; next group 0x305 (K28.5 RD+) -> 0xBC, ko=1, rd=0.
- 0x274 (D0.0 RD-) -> dataout=0x00, ko=0, rd=0; then 0x2AA (D21.5, neutral) -> dataout=0xB5, rd stays 0.
- 0x0FA sent twice back-to-back -> second group: dataout=0xBC, disp_err=1, code_err=0, rd=1, err_count=1.
- 0x000 -> code_err=1, err_count increments; toggling ena low for 3 cycles in between -> valid=0 and outputs/rd held throughout.
- D17.7 at RD-: abcdei 100011 + fghj 0111 -> 0xF1, no error; same 6b with fghj 1110 -> code_err=1.
- ERR_CNT_W=2: 5 consecutive 0x000 -> err_count saturates at 3; err_clr together with a 6th bad group -> err_count=0; reset asserted mid-stream -> all outputs 0 immediately.
